ir_receiver: RTL and testbench
==============================

IR_RECEIVER -- requirements
Module: ir_receiver

Interface
REQ-001 Parameter US_DIV, default 50, clk cycles per microsecond tick (50 MHz clk); legal range 2..1000.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ir_rx  input  1  demodulated IR line, active-low (0 = carrier mark), asynchronous to clk.
REQ-005 code  output  16  last accepted frame, {address byte, command byte}; feeds IR_decoder IR_in.
REQ-006 latch  output  1  one-clk-cycle high pulse when code is updated; feeds IR_decoder latch.
REQ-007 err  output  1  one-clk-cycle high pulse when a started frame is aborted.
REQ-008 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-009 ir_rx SHALL pass a 2-flop synchronizer; fall/rise edges are detected on the synchronized signal (edge visible 3 clk after input change).
REQ-010 A prescaler SHALL generate a 1-cycle tick every US_DIV clk; duration counter dur (14 bits) increments on tick, saturates at 16383, clears to 0 on every detected edge.
REQ-011 Windows in us (inclusive): leader mark 8000..10000; leader space 4000..5000; bit mark 400..700; space "0" 400..700; space "1" 1400..1900.
REQ-012 States: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE.
REQ-013 IDLE: on falling edge -> LEAD_MARK, bit counter=0, shift register=0; rising edges ignored.
REQ-014 LEAD_MARK: rising edge with dur in window -> LEAD_SPACE; else abort.
REQ-015 LEAD_SPACE: falling edge with dur in window -> BIT_MARK; else abort.
REQ-016 BIT_MARK: rising edge with dur in bit-mark window -> BIT_SPACE; else abort.
REQ-017 BIT_SPACE: falling edge classifies bit by dur (0 or 1 window, else abort); bit shifted in LSB-first; bit counter increments; if counter reaches 32 -> frame complete, else -> BIT_MARK.
REQ-018 Frame byte order received: addr, ~addr, cmd, ~cmd (each LSB-first).
REQ-019 Timeout: in any non-IDLE state, dur exceeding that state's upper bound SHALL abort immediately without waiting for an edge.
REQ-020 Abort: err pulses 1 cycle, FSM -> IDLE, code unchanged, no latch.
REQ-021 Frame complete: on the clk after the 32nd classifying edge, code={addr,cmd} and latch=1 for exactly one cycle; FSM -> IDLE.
REQ-022 Stop-bit mark following frame completion SHALL NOT start a new frame (IDLE only reacts to falling edges).
REQ-023 latch and err SHALL never be high in the same cycle; code stable except on the latch cycle.
REQ-024 Bit counter 6 bits; values above 32 unreachable.

Reset
REQ-025 Reset asserted: FSM=IDLE, code=16'h0000, latch=0, err=0, busy=0, dur=0, prescaler=0, synchronizer flops=1 (line idle).
REQ-026 Reset mid-frame SHALL discard partial frame with no latch or err pulse; after release, FSM waits for a fresh falling edge.

Configuration
REQ-027 Macro IR_CHECK_EN defined: at frame completion, address byte must equal ~(second byte) and command byte ~(fourth byte); mismatch -> abort per REQ-020.
REQ-028 IR_CHECK_EN undefined: complement bytes received but ignored; every 32-bit frame passing timing checks latches.

Verification (US_DIV=4 for speed)
REQ-029 Valid frame addr 0x0A, cmd 0x0B, complements correct -> one latch pulse, code=16'h0A0B, err=0.
REQ-030 Frame addr 0x0A cmd 0x04 with fourth byte 0xFF -> IR_CHECK_EN: err pulse, code unchanged; undefined: latch, code=16'h0A04.
REQ-031 Leader mark 6000 us -> err pulse at rising edge, FSM IDLE, no latch.
REQ-032 Line held low after 20th bit mark starts -> err pulse when dur reaches 701 us, busy falls same cycle as err.
REQ-033 reset asserted during bit 15 then released; next valid frame 0x0A12 -> single latch, code=16'h0A12, no err.
REQ-034 Two back-to-back valid frames 0x0A02 then 0x0A10 separated by 560 us stop mark and 40 ms idle -> two latch pulses, code updates in order.

Source files
------------

// File: rtl/ir_receiver.sv
// NEC-style IR frame receiver: synchronizes the active-low IR line, times marks/spaces
// in microseconds and assembles 32-bit frames into {addr, cmd}. Optional IR_CHECK_EN.
module ir_receiver #(
    parameter int US_DIV = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_rx,
    output logic [15:0] code,
    output logic        latch,
    output logic        err,
    output logic        busy
);

    localparam int PW = (US_DIV > 1) ? $clog2(US_DIV) : 1;

    localparam logic [13:0] LM_MIN  = 14'd8000;
    localparam logic [13:0] LM_MAX  = 14'd10000;
    localparam logic [13:0] LS_MIN  = 14'd4000;
    localparam logic [13:0] LS_MAX  = 14'd5000;
    localparam logic [13:0] BM_MIN  = 14'd400;
    localparam logic [13:0] BM_MAX  = 14'd700;
    localparam logic [13:0] S0_MIN  = 14'd400;
    localparam logic [13:0] S0_MAX  = 14'd700;
    localparam logic [13:0] S1_MIN  = 14'd1400;
    localparam logic [13:0] S1_MAX  = 14'd1900;
    localparam logic [13:0] DUR_SAT = 14'd16383;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE
    } state_t;

    state_t        state, state_nxt;
    logic          rx_s1, rx_s2, rx_d;
    logic          fall, rise;
    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic [13:0]   dur;
    logic [5:0]    bit_cnt, bit_cnt_nxt;
    logic [31:0]   shreg, shreg_nxt;
    logic [31:0]   sr_shift;
    logic [15:0]   code_nxt;
    logic          latch_nxt, err_nxt;
    logic          abort, bit_ok, bit_val, frame_ok;

    function automatic logic in_win(input logic [13:0] d, input logic [13:0] lo,
                                    input logic [13:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    // Flops reset to 1 so the idle line produces no spurious edge after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= ir_rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign fall = rx_d & ~rx_s2;
    assign rise = ~rx_d & rx_s2;

    assign tick = (pre_cnt == PW'(US_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      dur <= '0;
        else if (fall || rise)          dur <= '0;
        else if (tick && dur != DUR_SAT) dur <= dur + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            code    <= '0;
            latch   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            code    <= code_nxt;
            latch   <= latch_nxt;
            err     <= err_nxt;
        end
    end

    // Bits arrive LSB-first, so shift in from the top; byte 0 ends up in [7:0].
    assign sr_shift = {bit_val, shreg[31:1]};

`ifdef IR_CHECK_EN
    assign frame_ok = (sr_shift[7:0] == ~sr_shift[15:8]) &&
                      (sr_shift[23:16] == ~sr_shift[31:24]);
`else
    assign frame_ok = 1'b1;
`endif

    always_comb begin
        bit_ok  = 1'b0;
        bit_val = 1'b0;
        if (in_win(dur, S0_MIN, S0_MAX)) begin
            bit_ok = 1'b1;
        end else if (in_win(dur, S1_MIN, S1_MAX)) begin
            bit_ok  = 1'b1;
            bit_val = 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        code_nxt    = code;
        latch_nxt   = 1'b0;
        err_nxt     = 1'b0;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt   = LEAD_MARK;
                    bit_cnt_nxt = '0;
                    shreg_nxt   = '0;
                end
            end
            LEAD_MARK: begin
                if (rise) begin
                    if (in_win(dur, LM_MIN, LM_MAX)) state_nxt = LEAD_SPACE;
                    else                             abort = 1'b1;
                end else if (dur > LM_MAX) begin
                    abort = 1'b1;
                end
            end
            LEAD_SPACE: begin
                if (fall) begin
                    if (in_win(dur, LS_MIN, LS_MAX)) state_nxt = BIT_MARK;
                    else                             abort = 1'b1;
                end else if (dur > LS_MAX) begin
                    abort = 1'b1;
                end
            end
            BIT_MARK: begin
                if (rise) begin
                    if (in_win(dur, BM_MIN, BM_MAX)) state_nxt = BIT_SPACE;
                    else                             abort = 1'b1;
                end else if (dur > BM_MAX) begin
                    abort = 1'b1;
                end
            end
            BIT_SPACE: begin
                if (fall) begin
                    if (!bit_ok) begin
                        abort = 1'b1;
                    end else begin
                        shreg_nxt   = sr_shift;
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        if (bit_cnt == 6'd31) begin
                            if (frame_ok) begin
                                code_nxt  = {sr_shift[7:0], sr_shift[23:16]};
                                latch_nxt = 1'b1;
                                state_nxt = IDLE;
                            end else begin
                                abort = 1'b1;
                            end
                        end else begin
                            state_nxt = BIT_MARK;
                        end
                    end
                end else if (dur > S1_MAX) begin
                    abort = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ir_receiver.sv
// Scoreboard bench for ir_receiver: drives NEC frames on ir_rx, queues expected
// latch/err events and checks them as the DUT emits them.
module tb_ir_receiver;

    localparam int US_DIV = 4;

    typedef struct {
        logic        is_err;
        logic [15:0] code;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ir_rx = 1'b1;
    logic [15:0] code;
    logic        latch, err, busy;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_code = 16'h0000;
    logic [15:0] prev_code = 16'h0000;

    ir_receiver #(.US_DIV(US_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .ir_rx (ir_rx),
        .code  (code),
        .latch (latch),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic line(input logic v, input int us);
        ir_rx = v;
        repeat (us * US_DIV) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            line(1'b0, 560);
            line(1'b1, w[i] ? 1690 : 560);
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] na,
                              input logic [7:0] c, input logic [7:0] nc);
        line(1'b0, 9000);
        line(1'b1, 4500);
        send_bits({nc, c, na, a}, 32);
        line(1'b0, 560);
        line(1'b1, 2000);
    endtask

    task automatic push(input logic is_err, input logic [15:0] c);
        exp_t e;
        e.is_err = is_err;
        e.code   = c;
        sb.push_back(e);
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: every latch/err pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (latch && err) chk("latch_err_excl", 1, 0);
            if (!latch && code != prev_code) chk("code_stable", code, prev_code);
            if (latch || err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_evt", {30'd0, latch, err}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("evt_is_err", err, e.is_err);
                    chk("evt_code", code, e.code);
                    if (err) chk("busy_at_err", busy, 0);
                end
            end
        end
        prev_code = code;
    end

    initial begin
        int cnt;
        repeat (5) @(negedge clk);
        chk("rst_code", code, 16'h0000);
        chk("rst_latch", latch, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        line(1'b1, 1000);
        chk("idle_busy", busy, 0);

        // Valid frame 0x0A0B
        push(1'b0, 16'h0A0B);
        exp_code = 16'h0A0B;
        send_frame(8'h0A, 8'hF5, 8'h0B, 8'hF4);
        drain(5000);
        chk("code_0a0b", code, 16'h0A0B);

        // Bad fourth byte
`ifdef IR_CHECK_EN
        push(1'b1, exp_code);
`else
        push(1'b0, 16'h0A04);
        exp_code = 16'h0A04;
`endif
        send_frame(8'h0A, 8'hF5, 8'h04, 8'hFF);
        drain(5000);
        chk("code_after_bad_inv", code, exp_code);

        // Short leader mark aborts at its rising edge
        push(1'b1, exp_code);
        line(1'b0, 6000);
        line(1'b1, 2000);
        drain(5000);
        chk("busy_after_short_lead", busy, 0);

        // Line stuck low during the 20th bit mark
        push(1'b1, exp_code);
        line(1'b0, 9000);
        line(1'b1, 4500);
        send_bits(32'hF40BF50A, 19);
        ir_rx = 1'b0;
        cnt = 0;
        while (!err && cnt < 4000) begin
            @(negedge clk);
            cnt++;
        end
        chk("timeout_cycles_in_range", (cnt >= 2800 && cnt <= 2815) ? 32'd1 : cnt, 1);
        line(1'b0, 100);
        line(1'b1, 2000);
        drain(100);

        // Reset during bit 15, then a fresh valid frame
        line(1'b0, 9000);
        line(1'b1, 4500);
        send_bits(32'hED12F50A, 14);
        ir_rx = 1'b0;
        repeat (200 * US_DIV) @(negedge clk);
        chk("busy_mid_frame", busy, 1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst2_busy", busy, 0);
        chk("rst2_code", code, 16'h0000);
        ir_rx = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        exp_code = 16'h0000;
        line(1'b1, 2000);
        chk("rst2_idle", busy, 0);
        push(1'b0, 16'h0A12);
        exp_code = 16'h0A12;
        send_frame(8'h0A, 8'hF5, 8'h12, 8'hED);
        drain(5000);
        chk("code_0a12", code, 16'h0A12);

        // Back-to-back frames separated by stop mark and 40 ms idle
        push(1'b0, 16'h0A02);
        push(1'b0, 16'h0A10);
        send_frame(8'h0A, 8'hF5, 8'h02, 8'hFD);
        chk("code_0a02", code, 16'h0A02);
        line(1'b1, 38000);
        send_frame(8'h0A, 8'hF5, 8'h10, 8'hEF);
        drain(5000);
        chk("code_0a10", code, 16'h0A10);
        chk("final_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
